// File: rtl/fpu_adder.sv
// fpu_adder: sequential adder/subtractor for a 32-bit float {sign, 6-bit exp (bias 31), 25-bit frac}.
// Walks READ -> ALIGN -> ADD -> NORM -> ROUND -> WRITE and recomputes continuously.
// Optional build macro FPU_ROUND_NEAREST_EN: defined = round to nearest even, undefined = truncate.
module fpu_adder (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [31:0] op_A_in,
    input  logic [31:0] op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [2:0] {
        S_READ,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_WRITE
    } state_t;

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0010;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0100;
    localparam logic [3:0] ST_INEXACT   = 4'b1000;

    state_t             state;
    logic               sign_x;
    logic               sign_y;
    logic signed [7:0]  exp_x;      // wide enough for +2 overflow and -28 underflow excursions
    logic [5:0]         exp_diff;
    logic [28:0]        mant_x;     // {hidden, frac[24:0], guard, round, sticky}
    logic [28:0]        mant_y;
    logic [29:0]        sum;        // extra top bit catches the add carry-out
    logic [24:0]        res_frac;
    logic               inexact;
    logic               is_zero;

    // Operand unpacking and magnitude ordering used in READ
    logic [5:0]  a_exp;
    logic [5:0]  b_exp;
    logic [28:0] a_mant;
    logic [28:0] b_mant;
    logic        a_larger;

    // Expand operands and decide which one is larger in magnitude
    always_comb begin
        a_exp    = op_A_in[30:25];
        b_exp    = op_B_in[30:25];
        a_mant   = {(a_exp != 6'd0), op_A_in[24:0], 3'b000};
        b_mant   = {(b_exp != 6'd0), op_B_in[24:0], 3'b000};
        a_larger = ({a_exp, op_A_in[24:0]} >= {b_exp, op_B_in[24:0]});
    end

`ifdef FPU_ROUND_NEAREST_EN
    logic        round_up;
    logic [25:0] rounded;   // {carry, frac}; carry means the significand rolled over

    // Round-to-nearest-even increment decision on the normalized sum
    always_comb begin
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
        rounded  = {1'b0, sum[27:3]} + {25'd0, round_up};
    end
`endif

    // Main sequencer: all datapath registers and the registered outputs
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state      <= S_READ;
            sign_x     <= 1'b0;
            sign_y     <= 1'b0;
            exp_x      <= 8'sd0;
            exp_diff   <= 6'd0;
            mant_x     <= 29'd0;
            mant_y     <= 29'd0;
            sum        <= 30'd0;
            res_frac   <= 25'd0;
            inexact    <= 1'b0;
            is_zero    <= 1'b0;
            data_out   <= 32'd0;
            status_out <= 4'b0000;
        end else begin
            case (state)
                S_READ: begin
                    is_zero <= 1'b0;
                    inexact <= 1'b0;
                    if (a_larger) begin
                        sign_x   <= op_A_in[31];
                        sign_y   <= op_B_in[31];
                        exp_x    <= {2'b00, a_exp};
                        exp_diff <= a_exp - b_exp;
                        mant_x   <= a_mant;
                        mant_y   <= b_mant;
                        state    <= (a_exp == b_exp) ? S_ADD : S_ALIGN;
                    end else begin
                        sign_x   <= op_B_in[31];
                        sign_y   <= op_A_in[31];
                        exp_x    <= {2'b00, b_exp};
                        exp_diff <= b_exp - a_exp;
                        mant_x   <= b_mant;
                        mant_y   <= a_mant;
                        state    <= (a_exp == b_exp) ? S_ADD : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (exp_diff > 6'd27) begin
                        // Everything falls below sticky; a zero operand contributes nothing
                        mant_y   <= {28'd0, (mant_y != 29'd0)};
                        exp_diff <= 6'd0;
                        state    <= S_ADD;
                    end else begin
                        mant_y   <= {1'b0, mant_y[28:2], (mant_y[1] | mant_y[0])};
                        exp_diff <= exp_diff - 6'd1;
                        if (exp_diff == 6'd1) begin
                            state <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    if (sign_x == sign_y) begin
                        sum <= {1'b0, mant_x} + {1'b0, mant_y};
                    end else begin
                        sum <= {1'b0, mant_x} - {1'b0, mant_y};
                    end
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (sum == 30'd0) begin
                        is_zero <= 1'b1;
                        state   <= S_WRITE;
                    end else if (sum[29]) begin
                        sum   <= {1'b0, sum[29:2], (sum[1] | sum[0])};
                        exp_x <= exp_x + 8'sd1;
                        state <= S_ROUND;
                    end else if (sum[28]) begin
                        state <= S_ROUND;
                    end else begin
                        sum   <= {sum[28:0], 1'b0};
                        exp_x <= exp_x - 8'sd1;
                    end
                end
                S_ROUND: begin
                    inexact <= (sum[2:0] != 3'b000);
`ifdef FPU_ROUND_NEAREST_EN
                    if (rounded[25]) begin
                        res_frac <= 25'd0;
                        exp_x    <= exp_x + 8'sd1;
                    end else begin
                        res_frac <= rounded[24:0];
                    end
`else
                    res_frac <= sum[27:3];
`endif
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (is_zero) begin
                        data_out   <= 32'd0;
                        status_out <= ST_EXACT;
                    end else if (exp_x > 8'sd63) begin
                        data_out   <= {sign_x, 6'd63, 25'd0};
                        status_out <= ST_OVERFLOW;
                    end else if (exp_x < 8'sd1) begin
                        data_out   <= 32'd0;
                        status_out <= ST_UNDERFLOW;
                    end else if (inexact) begin
                        data_out   <= {sign_x, exp_x[5:0], res_frac};
                        status_out <= ST_INEXACT;
                    end else begin
                        data_out   <= {sign_x, exp_x[5:0], res_frac};
                        status_out <= ST_EXACT;
                    end
                    state <= S_READ;
                end
                default: state <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_adder.sv
// tb_fpu_adder: table-driven vectors with a scoreboard queue, plus reset corner sequences.
`timescale 1ns/1ps
module tb_fpu_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [3:0]  status;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  status;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    fpu_adder dut (
        .clock100KHz(clk),
        .reset      (rst_n),
        .op_A_in    (op_a),
        .op_B_in    (op_b),
        .data_out   (data_out),
        .status_out (status_out)
    );

    // 100 kHz clock
    initial clk = 1'b0;
    always #5000 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Poll for a non-zero status within a cycle budget; expiry counts as a failure
    task automatic wait_result(input string name, input int budget);
        int n;
        n = 0;
        while (status_out == 4'b0000 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (status_out == 4'b0000) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required<%0d", name, n, budget);
        end
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{32'h00000000, 32'h00000000, 32'h00000000, 4'b0001, "zero_plus_zero"};
        vecs[1]  = '{32'h3E000000, 32'h3E000000, 32'h40000000, 4'b0001, "one_plus_one"};
        vecs[2]  = '{32'h3E000000, 32'hBE000000, 32'h00000000, 4'b0001, "one_minus_one"};
        vecs[3]  = '{32'hC0000000, 32'hC0000000, 32'hC2000000, 4'b0001, "neg2_plus_neg2"};
        vecs[4]  = '{32'h64000064, 32'h14000064, 32'h64000064, 4'b1000, "far_apart_inexact"};
        vecs[5]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7E000000, 4'b0010, "overflow"};
        vecs[6]  = '{32'h02000001, 32'h82000000, 32'h00000000, 4'b0100, "underflow"};
        vecs[7]  = '{32'h40000000, 32'hBE000000, 32'h3E000000, 4'b0001, "two_minus_one"};
        vecs[8]  = '{32'h3E000000, 32'hC0000000, 32'hBE000000, 4'b0001, "one_minus_two_swap"};
        vecs[9]  = '{32'h3E000000, 32'h0A000000, 32'h3E000000, 4'b1000, "tie_to_even_diff26"};
        vecs[10] = '{32'h3E000000, 32'h06000000, 32'h3E000000, 4'b1000, "sticky_diff28"};
        vecs[11] = '{32'h00000000, 32'h3E000001, 32'h3E000001, 4'b0001, "zero_plus_x"};
        vecs[12] = '{32'h3E000000, 32'h3F000000, 32'h40800000, 4'b0001, "one_plus_1p5"};

        rst_n = 1'b0;
        op_a  = 32'h0;
        op_b  = 32'h0;
        repeat (3) @(negedge clk);
        check32("reset_data", data_out, 32'h0);
        check4("reset_status", status_out, 4'b0000);

        // First result after reset release must show up within 64 cycles
        rst_n = 1'b1;
        wait_result("first_result", 64);
        check32("first_data", data_out, 32'h0);
        check4("first_status", status_out, 4'b0001);

        for (int i = 0; i < 13; i++) begin
            op_a = vecs[i].a;
            op_b = vecs[i].b;
            sb.push_back('{vecs[i].data, vecs[i].status, vecs[i].name});
            // two full computation windows guarantee the new inputs have been processed
            repeat (130) @(negedge clk);
            e = sb.pop_front();
            $display("TXN %0d %s A=%h B=%h data=%h status=%b", i, e.name, op_a, op_b, data_out, status_out);
            check32({e.name, "_data"}, data_out, e.data);
            check4({e.name, "_status"}, status_out, e.status);
        end

        // Abort a computation with reset: outputs clear at once, then recover
        op_a = 32'h3E000000;
        op_b = 32'h3E000000;
        repeat (3) @(posedge clk);
        #2000;
        rst_n = 1'b0;
        #1;
        check32("midreset_data", data_out, 32'h0);
        check4("midreset_status", status_out, 4'b0000);
        repeat (3) @(negedge clk);
        check4("midreset_hold_status", status_out, 4'b0000);
        rst_n = 1'b1;
        sb.push_back('{32'h40000000, 4'b0001, "after_midreset"});
        wait_result("after_midreset", 64);
        e = sb.pop_front();
        $display("TXN midreset %s A=%h B=%h data=%h status=%b", e.name, op_a, op_b, data_out, status_out);
        check32({e.name, "_data"}, data_out, e.data);
        check4({e.name, "_status"}, status_out, e.status);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
